// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter that shares one pipelined adder tree among several requesters.
// A tag pipeline tracks each operation so its sum returns to the requester that issued it.
module adder_tree_arbiter #(
  parameter int bitwidth = 8,
  parameter int numberOfAddends = 9,
  parameter int numberOfRequesters = 4,
  parameter int treeLatency = 4,
  localparam int sumWidth = bitwidth + $clog2(numberOfAddends),
  localparam int idWidth = $clog2(numberOfRequesters),
  localparam int vectorWidth = numberOfAddends * bitwidth
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic [numberOfRequesters-1:0]          req_valid,
  output logic [numberOfRequesters-1:0]          req_ready,
  input  logic [numberOfRequesters*vectorWidth-1:0] req_values,
  output logic [vectorWidth-1:0]                 tree_values,
  output logic                                   tree_valid,
  input  logic [sumWidth-1:0]                    tree_sum,
  output logic                                   resp_valid,
  output logic [idWidth-1:0]                     resp_id,
  output logic [sumWidth-1:0]                    resp_sum,
  output logic                                   idle
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t nextState;

  logic [idWidth-1:0]              rrPointer;
  logic [idWidth-1:0]              grantIdx;
  logic [idWidth-1:0]              grantOffset;
  logic [idWidth:0]                grantSum;
  logic                            grantFound;
  logic                            grantAllowed;
  logic                            transfer;
  logic [2*numberOfRequesters-1:0] doubledReq;
  logic [2*numberOfRequesters-1:0] shiftedReq;
  logic [numberOfRequesters-1:0]   rotatedReq;
  logic [vectorWidth-1:0]          selectedValues;

  logic [idWidth-1:0]              pendingId;
  logic [treeLatency-1:0]          tagValid;
  logic [idWidth-1:0]              tagId [treeLatency];
  logic                            anyTagValid;

  // Rotate the request vector so the pointer sits at bit 0, then take the lowest set bit.
  always_comb begin
    doubledReq  = {req_valid, req_valid};
    shiftedReq  = doubledReq >> rrPointer;
    rotatedReq  = shiftedReq[numberOfRequesters-1:0];
    grantFound  = 1'b0;
    grantOffset = '0;
    for (int i = numberOfRequesters - 1; i >= 0; i--) begin
      if (rotatedReq[i]) begin
        grantFound  = 1'b1;
        grantOffset = idWidth'(i);
      end
    end
    grantSum = {1'b0, rrPointer} + {1'b0, grantOffset};
    if (grantSum >= (idWidth+1)'(numberOfRequesters)) begin
      grantSum = grantSum - (idWidth+1)'(numberOfRequesters);
    end
    grantIdx = grantSum[idWidth-1:0];
  end

  assign grantAllowed = (state == RUN) && enable;
  assign req_ready    = (grantAllowed && grantFound) ?
                        (numberOfRequesters'(1) << grantIdx) : '0;
  assign transfer     = |req_ready;

  always_comb begin
    selectedValues = '0;
    for (int i = 0; i < numberOfRequesters; i++) begin
      if (req_ready[i]) begin
        selectedValues = req_values[i*vectorWidth +: vectorWidth];
      end
    end
  end

  assign anyTagValid = |tagValid;
  assign idle        = (state == IDLE) && !anyTagValid;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (enable) nextState = RUN;
      end
      RUN: begin
        if (!enable) nextState = anyTagValid ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (enable)            nextState = RUN;
        else if (!anyTagValid) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rrPointer   <= '0;
      tree_values <= '0;
      tree_valid  <= 1'b0;
      pendingId   <= '0;
    end else begin
      state      <= nextState;
      tree_valid <= transfer;
      if (transfer) begin
        tree_values <= selectedValues;
        pendingId   <= grantIdx;
        rrPointer   <= (grantIdx == idWidth'(numberOfRequesters - 1)) ?
                       '0 : grantIdx + idWidth'(1);
      end
    end
  end

  // Tags shift every cycle regardless of grants, so the exit stage lines up with tree_sum.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tagValid   <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      for (int s = 0; s < treeLatency; s++) begin
        tagId[s] <= '0;
      end
    end else begin
      tagValid[0] <= tree_valid;
      tagId[0]    <= pendingId;
      for (int s = 1; s < treeLatency; s++) begin
        tagValid[s] <= tagValid[s-1];
        tagId[s]    <= tagId[s-1];
      end
      resp_valid <= tagValid[treeLatency-1];
      if (tagValid[treeLatency-1]) begin
        resp_id  <= tagId[treeLatency-1];
        resp_sum <= tree_sum;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Directed bench for adder_tree_arbiter with a behavioural 4-stage adder tree behind it.
module tb_adder_tree_arbiter;

  localparam int W = 72;

  logic          clock;
  logic          reset_n;
  logic          enable;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [4*W-1:0] req_values;
  logic [W-1:0]  tree_values;
  logic          tree_valid;
  logic [11:0]   tree_sum;
  logic          resp_valid;
  logic [1:0]    resp_id;
  logic [11:0]   resp_sum;
  logic          idle;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    int         reqId;
    logic [W-1:0] operands;
    int         expSum;
    logic [3:0] expReady;
  } vector_t;

  vector_t vectors [5];
  logic [11:0] treePipe [4];

  adder_tree_arbiter dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_values(req_values),
    .tree_values(tree_values),
    .tree_valid(tree_valid),
    .tree_sum(tree_sum),
    .resp_valid(resp_valid),
    .resp_id(resp_id),
    .resp_sum(resp_sum),
    .idle(idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [11:0] sumOf(input logic [W-1:0] v);
    int s = 0;
    for (int j = 0; j < 9; j++) s += int'(v[j*8 +: 8]);
    return 12'(s);
  endfunction

  // Stand-in adder tree: sum available four edges after the operands are registered.
  always @(posedge clock) begin
    treePipe[0] <= sumOf(tree_values);
    for (int i = 1; i < 4; i++) treePipe[i] <= treePipe[i-1];
  end
  assign tree_sum = treePipe[3];

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic setAllValues();
    for (int i = 0; i < 4; i++) req_values[i*W +: W] = {9{8'(i+1)}};
  endtask

  task automatic applyStimulus(input vector_t v);
    int waited;
    req_values = '0;
    req_values[v.reqId*W +: W] = v.operands;
    req_valid = 4'b0001 << v.reqId;
    #1 checkOutput("req_ready", int'(req_ready), int'(v.expReady));
    @(negedge clock);
    req_valid = '0;
    checkOutput("tree_valid", int'(tree_valid), 1);
    checkOutput("tree_values", int'(tree_values == v.operands), 1);
    @(negedge clock);
    checkOutput("tree_hold", int'(!tree_valid && tree_values == v.operands), 1);
    waited = 2;
    while (!resp_valid && waited < 12) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("resp_latency", waited, 6);
    if (resp_valid) begin
      checkOutput("resp_id", int'(resp_id), v.reqId);
      checkOutput("resp_sum", int'(resp_sum), v.expSum);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] wrapValid [5];
    logic [3:0] wrapExp [5];
    logic       respSeen;

    vectors[0] = '{2, {8'd9, 8'd16, 8'd21, 8'd24, 8'd25, 8'd24, 8'd21, 8'd16, 8'd9}, 165, 4'b0100};
    vectors[1] = '{0, {9{8'd255}}, 2295, 4'b0001};
    vectors[2] = '{1, {9{8'd0}}, 0, 4'b0010};
    vectors[3] = '{2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd1}, 256, 4'b0100};
    vectors[4] = '{3, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 45, 4'b1000};
    wrapValid = '{4'b1000, 4'b1010, 4'b1010, 4'b0000, 4'b1111};
    wrapExp   = '{4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0001};

    reset_n = 1'b0;
    enable = 1'b0;
    req_valid = '0;
    req_values = '0;
    #2;
    checkOutput("reset_tree_valid", int'(tree_valid), 0);
    checkOutput("reset_tree_values", int'(tree_values == '0), 1);
    checkOutput("reset_resp_valid", int'(resp_valid), 0);
    checkOutput("reset_resp_id", int'(resp_id), 0);
    checkOutput("reset_resp_sum", int'(resp_sum), 0);
    checkOutput("reset_idle", int'(idle), 1);
    @(negedge clock);
    reset_n = 1'b1;

    // First enabled cycle is spent leaving IDLE, so no grant yet.
    @(negedge clock);
    enable = 1'b1;
    req_valid = 4'b0100;
    #1 checkOutput("no_grant_in_idle", int'(req_ready), 0);
    req_valid = '0;
    @(negedge clock);
    checkOutput("run_not_idle", int'(idle), 0);

    for (int r = 0; r < 5; r++) applyStimulus(vectors[r]);

    // Fairness: pointer is 0 after the last grant to requester 3.
    setAllValues();
    for (int n = 0; n < 16; n++) begin
      if (n >= 6 && n <= 13) begin
        checkOutput("fair_resp_valid", int'(resp_valid), 1);
        checkOutput("fair_resp_id", int'(resp_id), (n - 6) % 4);
        checkOutput("fair_resp_sum", int'(resp_sum), 9 * ((n - 6) % 4 + 1));
      end else if (n != 0) begin
        checkOutput("fair_resp_quiet", int'(resp_valid), 0);
      end
      req_valid = (n < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (n < 8) checkOutput("fair_grant", int'(req_ready), 1 << (n % 4));
      @(negedge clock);
    end

    for (int n = 0; n < 5; n++) begin
      req_valid = wrapValid[n];
      #1 checkOutput("wrap_grant", int'(req_ready), int'(wrapExp[n]));
      @(negedge clock);
    end
    req_valid = '0;
    repeat (8) @(negedge clock);

    // Drain: pointer is 1; three grants, then enable falls with requests still pending.
    for (int n = 0; n < 11; n++) begin
      if (n >= 6 && n <= 8) begin
        checkOutput("drain_resp_valid", int'(resp_valid), 1);
        checkOutput("drain_resp_id", int'(resp_id), n - 5);
        checkOutput("drain_resp_sum", int'(resp_sum), 9 * (n - 4));
      end else begin
        checkOutput("drain_resp_quiet", int'(resp_valid), 0);
      end
      checkOutput("drain_idle", int'(idle), (n >= 9) ? 1 : 0);
      enable = (n < 3);
      req_valid = 4'b1111;
      #1 checkOutput("drain_grant", int'(req_ready), (n < 3) ? (1 << (n + 1)) : 0);
      @(negedge clock);
    end
    req_valid = '0;

    // Reset with two operations in flight.
    enable = 1'b1;
    @(negedge clock);
    req_valid = 4'b0001;
    #1 checkOutput("pre_reset_grant0", int'(req_ready), 1);
    @(negedge clock);
    req_valid = 4'b0010;
    #1 checkOutput("pre_reset_grant1", int'(req_ready), 2);
    @(negedge clock);
    req_valid = 4'b1111;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_tree_valid", int'(tree_valid), 0);
    checkOutput("midreset_tree_values", int'(tree_values == '0), 1);
    checkOutput("midreset_resp_valid", int'(resp_valid), 0);
    checkOutput("midreset_resp_sum", int'(resp_sum), 0);
    checkOutput("midreset_resp_id", int'(resp_id), 0);
    checkOutput("midreset_idle", int'(idle), 1);
    checkOutput("midreset_req_ready", int'(req_ready), 0);
    @(negedge clock);
    reset_n = 1'b1;
    enable = 1'b0;
    req_valid = '0;
    respSeen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      respSeen = respSeen | resp_valid;
    end
    checkOutput("no_resp_after_reset", int'(respSeen), 0);

    enable = 1'b1;
    @(negedge clock);
    applyStimulus(vectors[4]);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/adder_tree_arbiter.md
Name: adder_tree_arbiter

Overview:
- Round-robin arbiter that shares one pipelined adder_tree among several requesters, e.g. parallel 3x3 convolution window generators.
- Accepts one 9-operand vector per cycle from the winning requester and drives the tree inputs.
- Tracks in-flight operations with a tag pipeline and returns each sum to the requester that issued it.
- Sits between the window generators and the adder_tree instance.

Parameters:
- bitwidth, 8, width of each unsigned addend.
- numberOfAddends, 9, operands per request; matches the adder_tree setting.
- numberOfRequesters, 4, number of requester ports; range 2..16.
- treeLatency, 4, clock cycles from tree input register to valid tree_sum; range 1..8.
- Derived localparams: sumWidth = bitwidth + $clog2(numberOfAddends); idWidth = $clog2(numberOfRequesters).

Ports:
- clock, input, 1: sole clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: permits new grants.
- req_valid, input, numberOfRequesters: request pending, one bit per requester.
- req_ready, output, numberOfRequesters: one-hot grant, combinational.
- req_values, input, numberOfRequesters*numberOfAddends*bitwidth: flattened operands; requester i occupies slice i.
- tree_values, output, numberOfAddends*bitwidth: registered operands to adder_tree.
- tree_valid, output, 1: tree_values holds a new operation this cycle.
- tree_sum, input, sumWidth: adder_tree result.
- resp_valid, output, 1: single-cycle response strobe; no backpressure.
- resp_id, output, idWidth: requester index for the response.
- resp_sum, output, sumWidth: registered copy of tree_sum.
- idle, output, 1: no operation in flight and state is IDLE.

Behaviour:
- Reset (async assert, sync release): tree_values=0, tree_valid=0, resp_valid=0, resp_id=0, resp_sum=0, idle=1, state=IDLE, rr pointer=0, tag pipeline cleared.
- Operations in flight at reset are discarded and never produce resp_valid.
- States and transitions:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0 and at least one tag is valid.
  - RUN -> IDLE when enable=0 and no tag is valid.
  - DRAIN -> IDLE when the tag pipeline empties.
  - DRAIN -> RUN when enable returns to 1.
- Grants occur only in RUN with enable=1. At most one req_ready bit is high, combinationally.
- Grant selection: first valid requester searching upward (with wrap) from the rr pointer.
- A transfer happens when req_valid[i] & req_ready[i]. On that edge the rr pointer becomes (i+1) mod numberOfRequesters. With no grant the pointer holds.
- Latency:
  - Transfer at edge k -> tree_values/tree_valid high during cycle k..k+1.
  - Tag {1, i} enters the tag pipeline at edge k+1.
  - resp_valid, resp_id=i and resp_sum=tree_sum are registered at edge k+1+treeLatency and stay high for one cycle.
- Throughput: one operation per cycle. Back-to-back grants yield back-to-back responses in grant order.
- Tag pipeline is a treeLatency-deep shift register of {valid, id}; it shifts every cycle unconditionally.
- resp_valid is driven only from a valid tag exiting the pipeline; tree_sum is ignored otherwise.
- tree_values holds its last value when tree_valid=0.
- Width: resp_sum equals tree_sum bit for bit. Full scale is 9*255=2295, which fits sumWidth=12 without overflow.
- Simultaneous events:
  - enable falling in the same cycle as a pending request: no grant that cycle.
  - A new grant can coincide with a response; the two are independent.
- A requester dropping req_valid without a grant is legal; no state changes.
- idle=1 iff state=IDLE and all tags are invalid.

Test Plan:
- Single request: enable=1, requester 2 presents {9,16,21,24,25,24,21,16,9}, tree returns 165 -> req_ready=0100 in the request cycle; tree_valid one cycle later; resp_valid with resp_id=2, resp_sum=165 exactly 1+4 cycles after the grant.
- Fairness: all 4 req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses return in the same order, one per cycle, ids matching.
- Pointer wrap: grant 3, then only requesters 1 and 3 valid -> next grant 1, then 3.
- Drain: 3 back-to-back grants, enable dropped on the next cycle -> no further req_ready; state DRAIN; all 3 responses delivered; idle=1 on the cycle after the last resp_valid.
- Reset mid-flight: reset_n pulsed low while 2 ops are in flight -> all outputs 0 immediately and idle=1; no resp_valid after release until a new grant.
- Max value: operands all 255 -> resp_sum=2295 with no truncation; operands {1..9} -> resp_sum=45.
